// File: rtl/ysyx_24070014_sram_responder_pkg.sv
// Shared definitions for the SRAM responder: FSM state type, bus widths and the byte-lane merge helper.
package ysyx_24070014_sram_responder_pkg;

  localparam int WORD_W = 32;
  localparam int MASK_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] f_mask_merge(
    input logic [WORD_W-1:0] i_old,
    input logic [WORD_W-1:0] i_new,
    input logic [MASK_W-1:0] i_mask
  );
    logic [WORD_W-1:0] w_res;
    w_res = i_old;
    for (int b = 0; b < MASK_W; b++) begin
      if (i_mask[b]) w_res[8*b +: 8] = i_new[8*b +: 8];
    end
    return w_res;
  endfunction

endpackage

// File: rtl/ysyx_24070014_sram_responder_if.sv
// Request/response bus between an initiator (master) and the SRAM responder (slave).
// rsp_err exists only when YSYX_24070014_SRAM_BOUNDS_CHECK_EN is defined.
interface ysyx_24070014_sram_responder_if;
  import ysyx_24070014_sram_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              req_wen;
  logic [WORD_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
  logic              rsp_err;
`endif

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
    , input rsp_err
`endif
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
    , output rsp_err
`endif
  );

endinterface

// File: rtl/ysyx_24070014_sram_responder_sram_array.sv
// Word-organised storage with a byte-masked synchronous write port and a registered read port.
// Contents are deliberately not reset.
module ysyx_24070014_SramArray
  import ysyx_24070014_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [WORD_W-1:0]     i_wdata,
  input  logic [MASK_W-1:0]     i_wmask,
  output logic [WORD_W-1:0]     o_rdata
);

  logic [WORD_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= f_mask_merge(r_mem[i_idx], i_wdata, i_wmask);
    // read register only moves on a read, so it holds through backpressure
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_24070014_sram_responder.sv
// SRAM responder: single-outstanding request/response FSM with configurable access latency.
// Address bounds checking is compiled in with YSYX_24070014_SRAM_BOUNDS_CHECK_EN.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | req_ready=1, waiting for a request
//   ST_BUSY | request latched, down-counter running to terminal count 0
//   ST_RESP | rsp_valid=1, response held until rsp_ready
module ysyx_24070014_sram_responder
  import ysyx_24070014_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input logic                             clk,
  input logic                             reset,
  ysyx_24070014_sram_responder_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr;
  logic              r_wen;
  logic [WORD_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rd_sel;
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
  logic              r_err;
`endif

  logic              w_accept;
  logic              w_enter_resp;
  logic [31:0]       w_a_addr;
  logic              w_a_wen;
  logic [WORD_W-1:0] w_a_wdata;
  logic [MASK_W-1:0] w_a_wmask;
  logic              w_oob;
  logic              w_we;
  logic              w_re;
  logic              w_rd_sel;
  logic [WORD_W-1:0] w_arr_rdata;
  logic              w_unused_addr;

  assign w_accept     = r_req_ready && bus.req_valid;
  assign w_enter_resp = ((LATENCY == 1) && w_accept) ||
                        ((r_state == ST_BUSY) && (r_cnt == '0));

  // With LATENCY=1 the access coincides with acceptance, so the live request is used
  assign w_a_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_a_wen   = (r_state == ST_IDLE) ? bus.req_wen   : r_wen;
  assign w_a_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;
  assign w_a_wmask = (r_state == ST_IDLE) ? bus.req_wmask : r_wmask;

`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
  assign w_oob         = (w_a_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign w_unused_addr = ^w_a_addr[1:0];
`else
  assign w_oob         = 1'b0;
  assign w_unused_addr = ^{w_a_addr[31:DEPTH_LOG2+2], w_a_addr[1:0]};
`endif

  assign w_we     = reset && w_enter_resp && w_a_wen && !w_oob;
  assign w_re     = reset && w_enter_resp && !w_a_wen && !w_oob;
  assign w_rd_sel = !w_a_wen && !w_oob;

  ysyx_24070014_SramArray #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (w_a_addr[DEPTH_LOG2+1:2]),
    .i_wdata (w_a_wdata),
    .i_wmask (w_a_wmask),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rd_sel    <= 1'b0;
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= bus.req_addr;
            r_wen       <= bus.req_wen;
            r_wdata     <= bus.req_wdata;
            r_wmask     <= bus.req_wmask;
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rd_sel    <= w_rd_sel;
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
              r_err       <= w_oob;
`endif
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rd_sel    <= w_rd_sel;
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
            r_err       <= w_oob;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_rd_sel    <= 1'b0;
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
            r_err       <= 1'b0;
`endif
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rd_sel    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rd_sel ? w_arr_rdata : '0;
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
  assign bus.rsp_err   = r_err;
`endif

endmodule

// File: tb/tb_ysyx_24070014_sram_responder.sv
// Bench for the SRAM responder: a LATENCY=1 and a LATENCY=4 instance checked against a word-array model.
module tb_ysyx_24070014_sram_responder;

  localparam int DL = 10;
  localparam int NW = 1 << DL;

  logic clk;
  logic rst1;
  logic rst4;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_mem   [2][NW];
  logic [3:0]  m_known [2][NW];

  ysyx_24070014_sram_responder_if if1 ();
  ysyx_24070014_sram_responder_if if4 ();

  ysyx_24070014_sram_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) u_l1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (if1)
  );

  ysyx_24070014_sram_responder #(.DEPTH_LOG2(DL), .LATENCY(4)) u_l4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  function automatic int f_lat(input int sel);
    return (sel == 0) ? 1 : 4;
  endfunction

  function automatic logic f_rr(input int sel);
    return (sel == 0) ? if1.req_ready : if4.req_ready;
  endfunction

  function automatic logic f_rv(input int sel);
    return (sel == 0) ? if1.rsp_valid : if4.rsp_valid;
  endfunction

  function automatic logic [31:0] f_rd(input int sel);
    return (sel == 0) ? if1.rsp_rdata : if4.rsp_rdata;
  endfunction

`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
  function automatic logic f_err(input int sel);
    return (sel == 0) ? if1.rsp_err : if4.rsp_err;
  endfunction
`endif

  task automatic drv_req(input int sel, input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] m);
    if (sel == 0) begin
      if1.req_valid = v; if1.req_addr = a; if1.req_wen = w; if1.req_wdata = d; if1.req_wmask = m;
    end else begin
      if4.req_valid = v; if4.req_addr = a; if4.req_wen = w; if4.req_wdata = d; if4.req_wmask = m;
    end
  endtask

  task automatic drv_rsp(input int sel, input logic r);
    if (sel == 0) if1.rsp_ready = r;
    else          if4.rsp_ready = r;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; expected values come from the word-array model.
  task automatic txn(input int sel, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input int hold, input bit noisy, output logic [31:0] got);
    int          n;
    int          lat;
    int          idx;
    bit          oob;
    bit          chk_data;
    logic [31:0] exp;
    idx = int'(addr[DL+1:2]);
    oob = 1'b0;
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
    oob = (addr[31:DL+2] != '0);
`endif
    chk_data = wen || oob || (m_known[sel][idx] == 4'hF);
    exp = (wen || oob) ? 32'h0 : m_mem[sel][idx];

    @(negedge clk);
    drv_rsp(sel, 1'b0);
    drv_req(sel, 1'b1, addr, wen, wdata, mask);
    n = 0;
    while (!f_rr(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before", 32'(f_rr(sel)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    forever begin
      if (noisy) drv_req(sel, 1'b1, 32'h20 | 32'($urandom_range(0, 7)), 1'b1, $urandom, 4'hF);
      else       drv_req(sel, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      if (f_rv(sel) || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(f_lat(sel)));
    got = f_rd(sel);
    if (chk_data) chk("rsp_rdata", got, exp);
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
    chk("rsp_err", 32'(f_err(sel)), 32'(oob));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(f_rv(sel)), 32'd1);
      chk("hold_rdata", f_rd(sel), got);
    end
    drv_rsp(sel, 1'b1);
    @(negedge clk);
    drv_rsp(sel, 1'b0);
    drv_req(sel, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    chk("req_ready_after", 32'(f_rr(sel)), 32'd1);
    chk("rsp_valid_after", 32'(f_rv(sel)), 32'd0);

    if (wen && !oob) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) begin
          m_mem[sel][idx][8*b +: 8] = wdata[8*b +: 8];
          m_known[sel][idx][b]      = 1'b1;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          sel;
    int          seen;

    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < NW; w++) begin
        m_mem[s][w]   = 32'h0;
        m_known[s][w] = 4'h0;
      end
    end
    rst1 = 1'b0;
    rst4 = 1'b0;
    drv_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drv_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    drv_rsp(0, 1'b0);
    drv_rsp(1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_req_ready", 32'(f_rr(s)), 32'd1);
      chk("reset_rsp_valid", 32'(f_rv(s)), 32'd0);
      chk("reset_rsp_rdata", f_rd(s), 32'h0);
    end
    rst1 = 1'b1;
    rst4 = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", 32'(f_rr(0)), 32'd1);

    // write then read at latency 1
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, got);
    chk("write_rdata_zero", got, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, got);
    chk("write_then_read", got, 32'hDEADBEEF);

    // byte-mask merge
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'hF, 0, 1'b0, got);
    txn(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'h5, 0, 1'b0, got);
    txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, got);
    chk("mask_merge", got, 32'h11BB33DD);

    // zero-mask write leaves storage unchanged
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, 1'b0, got);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, got);
    chk("zero_mask_noop", got, 32'h11BB33DD);

    // latency 4 with three cycles of backpressure
    txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 1'b0, got);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 3, 1'b0, got);
    chk("lat4_read", got, 32'hCAFEF00D);

    // reset two cycles after accepting a write
    @(negedge clk);
    drv_req(1, 1'b1, 32'h20, 1'b1, 32'h12345678, 4'hF);
    @(posedge clk);
    @(negedge clk);
    drv_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst4 = 1'b1;
    chk("midreset_req_ready", 32'(f_rr(1)), 32'd1);
    chk("midreset_rsp_valid", 32'(f_rv(1)), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (f_rv(1)) seen++;
    end
    chk("midreset_no_response", 32'(seen), 32'd0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, got);
    chk("midreset_old_data", got, 32'hCAFEF00D);

    // address beyond the array
`ifdef YSYX_24070014_SRAM_BOUNDS_CHECK_EN
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0, got);
    chk("oob_read_rdata", got, 32'h0);
    txn(0, 1'b1, 32'h1010, 32'h5A5A1234, 4'hF, 0, 1'b0, got);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, got);
    chk("oob_write_dropped", got, 32'h11BB33DD);
`else
    txn(0, 1'b1, 32'h1000, 32'h5A5A1234, 4'hF, 0, 1'b0, got);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, got);
    chk("alias_write", got, 32'h5A5A1234);
`endif

    // requests presented while busy are ignored
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 2, 1'b1, got);
    chk("busy_first_served", got, 32'hCAFEF00D);
    @(negedge clk);
    chk("busy_no_second", 32'(f_rv(1)), 32'd0);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, got);
    chk("busy_noise_not_written", got, 32'hCAFEF00D);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 1);
      a = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom_range(1, 255));
      txn(sel, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2), 1'b0, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
